// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg (package)
// Purpose  : Shared ALU definitions. Holds the ALU control codes, the default
//            datapath width and a round-robin pointer helper used by the
//            arbiter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int ALU_XLEN = 32;

  typedef enum logic [3:0] {
    ALU_CTL_AND = 4'd0,
    ALU_CTL_OR  = 4'd1,
    ALU_CTL_ADD = 4'd2,
    ALU_CTL_SUB = 4'd6,
    ALU_CTL_SLT = 4'd7,
    ALU_CTL_NOR = 4'd12
  } alu_ctl_e;

  // Next round-robin position after index idx, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin selector. Picks the first requester
//            that is both requesting and unmasked, searching upward from the
//            pointer and wrapping modulo NREQ.
// Ports    : i_req     [NREQ]  request vector
//            i_ptr     [PW]    search start position (0..NREQ-1)
//            i_mask    [NREQ]  eligibility mask, 1 = may be granted
//            o_gnt     [NREQ]  one-hot grant (zero when nothing eligible)
//            o_gnt_idx [PW]    index of the granted requester
//            o_gnt_any         a grant exists
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  input  logic [NREQ-1:0] i_mask,
  output logic [NREQ-1:0] o_gnt,
  output logic [PW-1:0]   o_gnt_idx,
  output logic            o_gnt_any
);

  always_comb begin
    int k;
    k         = 0;
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_gnt_any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      // Pointer is always below NREQ, so a single subtraction wraps it.
      k = int'(i_ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!o_gnt_any && i_req[k] && i_mask[k]) begin
        o_gnt[k]  = 1'b1;
        o_gnt_idx = PW'(k);
        o_gnt_any = 1'b1;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one combinational ALU between NREQ requesters with
//            round-robin grant. Each requester has a valid/ready request
//            channel and a valid/ready response channel. The ALU result is
//            registered into a single-entry response buffer (1-cycle latency,
//            1 op/cycle while responses drain).
// Config   : ALU_ARB_LOCK_EN - adds i_req_lock; an accept with the lock bit
//            set makes that requester the exclusive owner until it issues an
//            accept with the lock bit clear.
// Ports    : i_clk, i_rst_n (synchronous, active low)
//            i_req_valid/o_req_ready [NREQ], i_req_ctl [4*NREQ],
//            i_req_a/i_req_b [XLEN*NREQ]      request channel
//            o_rsp_valid/i_rsp_ready [NREQ], o_rsp_data [XLEN], o_rsp_zero
//                                              response channel
//            o_alu_ctl/o_alu_a/o_alu_b, i_alu_out/i_alu_zero  ALU hookup
//            i_req_lock [NREQ]                 only with ALU_ARB_LOCK_EN
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int XLEN = ALU_XLEN
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NREQ-1:0]      i_req_valid,
  output logic [NREQ-1:0]      o_req_ready,
  input  logic [4*NREQ-1:0]    i_req_ctl,
  input  logic [XLEN*NREQ-1:0] i_req_a,
  input  logic [XLEN*NREQ-1:0] i_req_b,
  output logic [NREQ-1:0]      o_rsp_valid,
  input  logic [NREQ-1:0]      i_rsp_ready,
  output logic [XLEN-1:0]      o_rsp_data,
  output logic                 o_rsp_zero,
  output logic [3:0]           o_alu_ctl,
  output logic [XLEN-1:0]      o_alu_a,
  output logic [XLEN-1:0]      o_alu_b,
  input  logic [XLEN-1:0]      i_alu_out,
  input  logic                 i_alu_zero
`ifdef ALU_ARB_LOCK_EN
  ,
  input  logic [NREQ-1:0]      i_req_lock
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_data_q,  rsp_data_d;
  logic            rsp_zero_q,  rsp_zero_d;
  logic [PW-1:0]   ptr_q,       ptr_d;

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_any;
  logic [NREQ-1:0] mask;
  logic            drain;
  logic            buf_free;
  logic            accept;

`ifdef ALU_ARB_LOCK_EN
  logic            lock_act_q, lock_act_d;
  logic [PW-1:0]   lock_own_q, lock_own_d;

  // A held lock narrows eligibility to the owner, even if it is idle.
  always_comb begin
    mask = '1;
    if (lock_act_q) mask = {{(NREQ-1){1'b0}}, 1'b1} << lock_own_q;
  end
`else
  always_comb begin
    mask = '1;
  end
`endif

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_arbiter (
    .i_req     (i_req_valid),
    .i_ptr     (ptr_q),
    .i_mask    (mask),
    .o_gnt     (gnt),
    .o_gnt_idx (gnt_idx),
    .o_gnt_any (gnt_any)
  );

  // Buffer can be refilled in the same cycle its owner drains it.
  always_comb begin
    drain       = |(rsp_valid_q & i_rsp_ready);
    buf_free    = ~(|rsp_valid_q) | drain;
    accept      = i_rst_n & buf_free & gnt_any;
    o_req_ready = accept ? gnt : '0;
  end

  // ALU sees the granted slot whenever a grant exists, stalled or not.
  always_comb begin
    o_alu_ctl = '0;
    o_alu_a   = '0;
    o_alu_b   = '0;
    if (gnt_any) begin
      o_alu_ctl = i_req_ctl[int'(gnt_idx)*4 +: 4];
      o_alu_a   = i_req_a[int'(gnt_idx)*XLEN +: XLEN];
      o_alu_b   = i_req_b[int'(gnt_idx)*XLEN +: XLEN];
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    ptr_d       = ptr_q;
    if (accept) begin
      rsp_valid_d = gnt;
      rsp_data_d  = i_alu_out;
      rsp_zero_d  = i_alu_zero;
      ptr_d       = PW'(rr_next(int'(gnt_idx), NREQ));
    end else if (drain) begin
      rsp_valid_d = '0;
    end
  end

`ifdef ALU_ARB_LOCK_EN
  // While locked only the owner can be accepted, so its lock bit on each
  // accept directly decides whether the lock continues.
  always_comb begin
    lock_act_d = lock_act_q;
    lock_own_d = lock_own_q;
    if (accept) begin
      lock_act_d = i_req_lock[gnt_idx];
      lock_own_d = gnt_idx;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      lock_act_q <= 1'b0;
      lock_own_q <= '0;
    end else begin
      lock_act_q <= lock_act_d;
      lock_own_q <= lock_own_d;
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      ptr_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
      ptr_q       <= ptr_d;
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_zero  = rsp_zero_q;

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter. Provides a behavioural ALU,
//            runs directed scenarios and randomized traffic against a
//            transaction-level reference model. ALU_ARB_LOCK_EN enables the
//            lock scenario and random lock bits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NREQ = 2;
  localparam int XLEN = 32;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [4*NREQ-1:0]    req_ctl;
  logic [XLEN*NREQ-1:0] req_a, req_b;
  logic [XLEN-1:0]      rsp_data, alu_a, alu_b, alu_out;
  logic                 rsp_zero, alu_zero;
  logic [3:0]           alu_ctl;
`ifdef ALU_ARB_LOCK_EN
  logic [NREQ-1:0]      req_lock;
`endif

  logic [3:0]      s_ctl [NREQ];
  logic [XLEN-1:0] s_a   [NREQ];
  logic [XLEN-1:0] s_b   [NREQ];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: one buffered response, a pointer, a lock.
  bit              m_valid;
  int              m_owner;
  logic [XLEN-1:0] m_data;
  bit              m_zero;
  int              m_ptr;
  bit              m_lock;
  int              m_lown;

  alu_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_ctl   (req_ctl),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data),
    .o_rsp_zero  (rsp_zero),
    .o_alu_ctl   (alu_ctl),
    .o_alu_a     (alu_a),
    .o_alu_b     (alu_b),
    .i_alu_out   (alu_out),
    .i_alu_zero  (alu_zero)
`ifdef ALU_ARB_LOCK_EN
    ,
    .i_req_lock  (req_lock)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] alu_ref(input logic [3:0] c,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    case (c)
      ALU_CTL_AND: return a & b;
      ALU_CTL_OR:  return a | b;
      ALU_CTL_ADD: return a + b;
      ALU_CTL_SUB: return a - b;
      ALU_CTL_SLT: return ($signed(a) < $signed(b)) ? XLEN'(1) : XLEN'(0);
      ALU_CTL_NOR: return ~(a | b);
      default:     return '0;
    endcase
  endfunction

  assign alu_out  = alu_ref(alu_ctl, alu_a, alu_b);
  assign alu_zero = (alu_out == '0);

  always_comb begin
    req_ctl = '0;
    req_a   = '0;
    req_b   = '0;
    for (int k = 0; k < NREQ; k++) begin
      req_ctl[4*k +: 4]       = s_ctl[k];
      req_a[XLEN*k +: XLEN]   = s_a[k];
      req_b[XLEN*k +: XLEN]   = s_b[k];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_slot(input int k, input logic [3:0] c,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    s_ctl[k] = c;
    s_a[k]   = a;
    s_b[k]   = b;
  endtask

  // Requester the model would grant, or -1.
  function automatic int model_grant();
    int k;
    for (int i = 0; i < NREQ; i++) begin
      k = (m_ptr + i) % NREQ;
      if (req_valid[k] && (!m_lock || k == m_lown)) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_owner = 0; m_data = '0; m_zero = 0;
    m_ptr = 0; m_lock = 0; m_lown = 0;
  endtask

  // One clock: compare everything visible against the model, then advance.
  task automatic step();
    int              g;
    bit              free;
    logic [NREQ-1:0] er;
    #1;
    free = !m_valid || rsp_ready[m_owner];
    g    = model_grant();
    er   = (rst_n && free && g >= 0) ? (NREQ'(1) << g) : '0;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("alu_ctl",   64'(alu_ctl),   (g >= 0) ? 64'(s_ctl[g]) : 64'd0);
    chk("alu_a",     64'(alu_a),     (g >= 0) ? 64'(s_a[g])   : 64'd0);
    chk("alu_b",     64'(alu_b),     (g >= 0) ? 64'(s_b[g])   : 64'd0);
    chk("rsp_valid", 64'(rsp_valid), m_valid ? (64'd1 << m_owner) : 64'd0);
    chk("rsp_data",  64'(rsp_data),  64'(m_data));
    chk("rsp_zero",  64'(rsp_zero),  64'(m_zero));
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (er != '0) begin
      m_valid = 1;
      m_owner = g;
      m_data  = alu_ref(s_ctl[g], s_a[g], s_b[g]);
      m_zero  = (m_data == '0);
      m_ptr   = (g + 1) % NREQ;
`ifdef ALU_ARB_LOCK_EN
      m_lock  = req_lock[g];
      m_lown  = g;
`endif
    end else if (m_valid && rsp_ready[m_owner]) begin
      m_valid = 0;
    end
    #1;
  endtask

  initial begin
    logic [3:0] codes [8];
    codes = '{ALU_CTL_AND, ALU_CTL_OR, ALU_CTL_ADD, ALU_CTL_SUB,
              ALU_CTL_SLT, ALU_CTL_NOR, 4'd15, 4'd3};
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
`ifdef ALU_ARB_LOCK_EN
    req_lock = '0;
`endif
    for (int k = 0; k < NREQ; k++) set_slot(k, 4'd0, '0, '0);
    model_reset();
    @(posedge clk);
    #1;
    step();                        // reset state observed through the model
    rst_n = 1'b1;

    // Single request ADD 5+7
    set_slot(0, ALU_CTL_ADD, 32'd5, 32'd7);
    req_valid = 2'b01;
    #1 chk("t1_ready", 64'(req_ready), 64'b01);
    step();
    chk("t1_rsp_valid", 64'(rsp_valid), 64'b01);
    chk("t1_data", 64'(rsp_data), 64'd12);
    chk("t1_zero", 64'(rsp_zero), 64'd0);

    // Both valid with free drain: grants alternate starting at 1
    set_slot(1, ALU_CTL_OR, 32'hF0, 32'h0F);
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t2_grant", 64'(req_ready), (i % 2 == 0) ? 64'b10 : 64'b01);
      step();
    end

    // Backpressure with SUB 9-9
    req_valid = 2'b00; step();
    set_slot(0, ALU_CTL_SUB, 32'd9, 32'd9);
    req_valid = 2'b01; rsp_ready = 2'b00;
    step();
    rsp_ready = 2'b10;             // non-owner ready must be ignored
    for (int i = 0; i < 3; i++) begin
      #1 chk("t3_stall_ready", 64'(req_ready), 64'd0);
      step();
      chk("t3_hold_valid", 64'(rsp_valid), 64'b01);
      chk("t3_hold_data", 64'(rsp_data), 64'd0);
      chk("t3_hold_zero", 64'(rsp_zero), 64'd1);
    end
    set_slot(0, ALU_CTL_ADD, 32'd1, 32'd1);
    rsp_ready = 2'b01;
    #1 chk("t3_drain_accept", 64'(req_ready), 64'b01);
    step();
    chk("t3_next_data", 64'(rsp_data), 64'd2);

    // Requester 1 only: SLT, NOR, undefined code
    req_valid = 2'b10; rsp_ready = 2'b11;
    set_slot(1, ALU_CTL_SLT, 32'd3, 32'd4);
    step();
    chk("t4_slt", 64'(rsp_data), 64'd1);
    chk("t4_slt_owner", 64'(rsp_valid), 64'b10);
    set_slot(1, ALU_CTL_NOR, 32'd0, 32'd0);
    step();
    chk("t4_nor", 64'(rsp_data), 64'hFFFF_FFFF);
    set_slot(1, 4'd15, 32'd5, 32'd6);
    step();
    chk("t4_undef_data", 64'(rsp_data), 64'd0);
    chk("t4_undef_zero", 64'(rsp_zero), 64'd1);

    // Reset with a response pending
    set_slot(0, ALU_CTL_ADD, 32'd2, 32'd3);
    req_valid = 2'b01; rsp_ready = 2'b00;
    step();
    rst_n = 1'b0; req_valid = 2'b11;
    #1 chk("t5_ready_in_rst", 64'(req_ready), 64'd0);
    step();
    chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t5_rsp_data", 64'(rsp_data), 64'd0);
    rst_n = 1'b1; rsp_ready = 2'b11;
    #1 chk("t5_ptr0", 64'(req_ready), 64'b01);
    step();

`ifdef ALU_ARB_LOCK_EN
    // Requester 0 locks; requester 1 starves until release
    req_lock = 2'b01; req_valid = 2'b01;
    #1 chk("t6_take_lock", 64'(req_ready), 64'b01);
    step();
    req_valid = 2'b11;
    for (int i = 0; i < 2; i++) begin
      #1 chk("t6_locked", 64'(req_ready), 64'b01);
      step();
    end
    req_valid = 2'b10;
    #1 chk("t6_owner_idle", 64'(req_ready), 64'd0);
    step();
    req_valid = 2'b11; req_lock = 2'b00;
    #1 chk("t6_release", 64'(req_ready), 64'b01);
    step();
    #1 chk("t6_req1_next", 64'(req_ready), 64'b10);
    step();
`endif

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst_n     = ($urandom_range(0, 49) != 0);
      req_valid = NREQ'($urandom);
      rsp_ready = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
`ifdef ALU_ARB_LOCK_EN
      req_lock  = ($urandom_range(0, 2) == 0) ? NREQ'($urandom) : '0;
`endif
      for (int k = 0; k < NREQ; k++) begin
        logic [XLEN-1:0] a;
        a = ($urandom_range(0, 3) == 0) ? XLEN'($urandom_range(0, 7)) : XLEN'($urandom);
        set_slot(k, codes[$urandom_range(0, 7)], a,
                 ($urandom_range(0, 3) == 0) ? a : XLEN'($urandom));
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_alu_arbiter
`default_nettype wire
